// File: rtl/fp_round_pipe_if.sv
// Handshake and data bundle for the renormalize-and-round stage.
// The slave modport is the rounding block; the master side is its driver/consumer.
interface fp_round_pipe_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  logic          i_valid;
  logic          o_ready_in;
  logic          i_sign;
  logic [EW-1:0] i_exp;
  logic [MW+4:0] i_mant;
  logic [2:0]    i_rm;
  logic          i_un_fl;
  logic          o_valid;
  logic          i_ready;
  logic          o_sign;
  logic [EW-1:0] o_exp;
  logic [MW-1:0] o_mant;
  logic          o_ov_fl;
  logic          o_un_fl;
  logic          o_nx;

  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_rm, i_un_fl, i_ready,
    output o_ready_in, o_valid, o_sign, o_exp, o_mant, o_ov_fl, o_un_fl, o_nx
  );

  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_rm, i_un_fl, i_ready,
    input  o_ready_in, o_valid, o_sign, o_exp, o_mant, o_ov_fl, o_un_fl, o_nx
  );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage renormalize-and-round pipeline: stage 1 rounds the extended mantissa,
// stage 2 renormalizes on carry-out and resolves specials and overflow.
module fp_round_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fp_round_pipe_if.slave     bus
);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0] EXP_MAXF = {{(EW-1){1'b1}}, 1'b0};

  logic ld1, ld2;
  logic v1_q, v2_q;

  logic          l_bit, g_bit, s_bit, nx0, inc, spec_in;
  logic [MW+1:0] sum_d;

  logic          s1_sign_q;
  logic [EW-1:0] s1_exp_q;
  logic [MW+1:0] s1_sum_q;
  logic          s1_nx_q;
  logic [2:0]    s1_rm_q;
  logic          s1_un_q;
  logic          s1_spec_q;

  logic          carry, to_inf, sat_ov;
  logic [EW-1:0] exp_r;
  logic          o_sign_d, o_ov_d, o_un_d, o_nx_d;
  logic [EW-1:0] o_exp_d;
  logic [MW-1:0] o_mant_d;
  logic          o_sign_q, o_ov_q, o_un_q, o_nx_q;
  logic [EW-1:0] o_exp_q;
  logic [MW-1:0] o_mant_q;

  assign ld2            = ~v2_q | bus.i_ready;
  assign ld1            = ~v1_q | ld2;
  assign bus.o_ready_in = ld1;
  assign bus.o_valid    = v2_q;
  assign bus.o_sign     = o_sign_q;
  assign bus.o_exp      = o_exp_q;
  assign bus.o_mant     = o_mant_q;
  assign bus.o_ov_fl    = o_ov_q;
  assign bus.o_un_fl    = o_un_q;
  assign bus.o_nx       = o_nx_q;

  // Specials never round, so their increment is suppressed and the sum carries the raw fraction.
  always_comb begin
    l_bit   = bus.i_mant[4];
    g_bit   = bus.i_mant[3];
    s_bit   = |bus.i_mant[2:0];
    nx0     = g_bit | s_bit;
    spec_in = (bus.i_exp == EXP_ONES);
    inc     = 1'b0;
    case (bus.i_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = bus.i_sign & nx0;
      RM_RUP:  inc = ~bus.i_sign & nx0;
      RM_RMM:  inc = g_bit;
      default: inc = g_bit & (s_bit | l_bit);
    endcase
    if (spec_in) inc = 1'b0;
    sum_d = {1'b0, bus.i_mant[MW+4:4]} + {{(MW+1){1'b0}}, inc};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_sum_q  <= '0;
      s1_nx_q   <= 1'b0;
      s1_rm_q   <= '0;
      s1_un_q   <= 1'b0;
      s1_spec_q <= 1'b0;
    end else if (ld1) begin
      v1_q      <= bus.i_valid;
      s1_sign_q <= bus.i_sign;
      s1_exp_q  <= bus.i_exp;
      s1_sum_q  <= sum_d;
      s1_nx_q   <= nx0;
      s1_rm_q   <= bus.i_rm;
      s1_un_q   <= bus.i_un_fl;
      s1_spec_q <= spec_in;
    end
  end

  // Directed-toward-zero modes never increment, so an inexact largest-magnitude
  // operand is flagged as overflow here and saturates to max finite.
  always_comb begin
    carry  = s1_sum_q[MW+1];
    exp_r  = s1_exp_q + {{(EW-1){1'b0}}, carry};
    to_inf = 1'b1;
    case (s1_rm_q)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s1_sign_q;
      RM_RUP:  to_inf = ~s1_sign_q;
      default: to_inf = 1'b1;
    endcase
    sat_ov = ~to_inf & s1_nx_q & ~carry & (s1_exp_q == EXP_MAXF) & (&s1_sum_q[MW:0]);

    o_sign_d = s1_sign_q;
    o_exp_d  = exp_r;
    o_mant_d = carry ? s1_sum_q[MW:1] : s1_sum_q[MW-1:0];
    o_ov_d   = 1'b0;
    o_un_d   = ~carry & s1_un_q;
    o_nx_d   = s1_nx_q;

    if (s1_spec_q) begin
      o_exp_d  = EXP_ONES;
      o_mant_d = s1_sum_q[MW-1:0];
      o_un_d   = 1'b0;
      o_nx_d   = 1'b0;
    end else if ((exp_r == EXP_ONES) || sat_ov) begin
      o_ov_d = 1'b1;
      o_nx_d = 1'b1;
      if (to_inf) begin
        o_exp_d  = EXP_ONES;
        o_mant_d = '0;
      end else begin
        o_exp_d  = EXP_MAXF;
        o_mant_d = '1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2_q     <= 1'b0;
      o_sign_q <= 1'b0;
      o_exp_q  <= '0;
      o_mant_q <= '0;
      o_ov_q   <= 1'b0;
      o_un_q   <= 1'b0;
      o_nx_q   <= 1'b0;
    end else if (ld2) begin
      v2_q     <= v1_q;
      o_sign_q <= o_sign_d;
      o_exp_q  <= o_exp_d;
      o_mant_q <= o_mant_d;
      o_ov_q   <= o_ov_d;
      o_un_q   <= o_un_d;
      o_nx_q   <= o_nx_d;
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Randomized and directed check of fp_round_pipe (EW=8, MW=23) against an
// arithmetic rounding model and an in-order scoreboard.
module tb_fp_round_pipe;

  typedef struct packed {
    logic        sign;
    logic [7:0]  e;
    logic [22:0] m;
    logic        ov;
    logic        un;
    logic        nx;
  } res_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  e;
    logic [27:0] mant;
    logic [2:0]  rm;
    logic        un;
  } beat_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  res_t exp_q[$];
  bit   held;
  res_t held_val;
  bit   rand_done;

  fp_round_pipe_if #(.EW(8), .MW(23)) bus ();

  fp_round_pipe #(.EW(8), .MW(23)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  // Value-level rounding: integer significand plus round-up, renormalize, then range check.
  function automatic res_t model(input bit s, input bit [7:0] e, input bit [27:0] mant,
                                 input bit [2:0] rm, input bit un);
    res_t   r;
    longint m;
    int     ee, mode;
    bit     g, st, nx0, up, inf_dir, exceeds;
    m    = longint'(mant >> 4);
    g    = mant[3];
    st   = (mant[2:0] != 3'd0);
    nx0  = g | st;
    mode = (rm > 3'd4) ? 0 : int'(rm);
    ee   = int'(e);
    r.sign = s;
    if (e == 8'd255) begin
      r.e = 8'd255; r.m = mant[26:4]; r.ov = 0; r.un = 0; r.nx = 0;
      return r;
    end
    case (mode)
      0:       up = g && (st || mant[4]);
      1:       up = 0;
      2:       up = s && nx0;
      3:       up = !s && nx0;
      default: up = g;
    endcase
    inf_dir = (mode == 0) || (mode == 4) || (mode == 3 && !s) || (mode == 2 && s);
    m    = m + (up ? 64'd1 : 64'd0);
    r.un = un;
    if (m >= (64'd1 << 24)) begin
      m    = m / 2;
      ee   = ee + 1;
      r.un = 0;
    end
    exceeds = (ee == 255) || (ee == 254 && m == (64'd1 << 24) - 1 && nx0 && !inf_dir);
    if (exceeds) begin
      r.ov = 1; r.nx = 1;
      if (inf_dir) begin r.e = 8'd255; r.m = 23'd0; end
      else begin r.e = 8'd254; r.m = 23'h7FFFFF; end
    end else begin
      r.e  = 8'(ee);
      r.m  = 23'(m % (64'd1 << 23));
      r.ov = 0;
      r.nx = nx0;
    end
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.o_sign, bus.o_exp, bus.o_mant, bus.o_ov_fl, bus.o_un_fl, bus.o_nx};
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 0;
    end else begin
      if (bus.o_valid) begin
        if (held) chk("stall_stable", 64'(dut_res()), 64'(held_val));
        if (bus.i_ready) begin
          held = 0;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got %h expected none", dut_res());
          end else begin
            chk("scoreboard", 64'(dut_res()), 64'(exp_q.pop_front()));
          end
        end else begin
          held     = 1;
          held_val = dut_res();
        end
      end else begin
        held = 0;
      end
      if (bus.i_valid && bus.o_ready_in)
        exp_q.push_back(model(bus.i_sign, bus.i_exp, bus.i_mant, bus.i_rm, bus.i_un_fl));
    end
  end

  task automatic drive(input beat_t b);
    bus.i_sign  = b.sign;
    bus.i_exp   = b.e;
    bus.i_mant  = b.mant;
    bus.i_rm    = b.rm;
    bus.i_un_fl = b.un;
    bus.i_valid = 1'b1;
  endtask

  task automatic send(input beat_t b);
    int n = 0;
    drive(b);
    @(negedge clk);
    while (!bus.o_ready_in && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL send_timeout: got o_ready_in=0 for %0d cycles expected 1", n);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.i_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Assumes an empty pipe and i_ready=1; checks 2-cycle latency and literal result.
  task automatic directed(input string name, input bit s, input logic [7:0] e,
                          input logic [27:0] m, input logic [2:0] rm, input bit un,
                          input res_t want);
    beat_t b;
    chk({name, "_model"}, 64'(model(s, e, m, rm, un)), 64'(want));
    b = {s, e, m, rm, un};
    bus.i_ready = 1'b1;
    drive(b);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk({name, "_lat1_valid"}, 64'(bus.o_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_lat2_valid"}, 64'(bus.o_valid), 64'd1);
    chk({name, "_result"}, 64'(dut_res()), 64'(want));
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    int    sel;
    b.sign = 1'($urandom);
    sel    = $urandom_range(0, 7);
    b.e    = (sel == 0) ? 8'hFE : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h00 : 8'($urandom);
    b.mant = 28'($urandom);
    if ($urandom_range(0, 7) != 0) b.mant[27] = 1'b1;
    if ($urandom_range(0, 3) == 0) b.mant[26:4] = '1;
    if ($urandom_range(0, 3) == 0) b.mant[3:0] = 4'b1000;
    b.rm = 3'($urandom_range(0, 7));
    b.un = 1'($urandom);
    return b;
  endfunction

  initial begin
    beat_t b;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_mant  = '0;
    bus.i_rm    = '0;
    bus.i_un_fl = 1'b0;
    bus.i_ready = 1'b1;
    rand_done   = 0;

    @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_outputs", 64'(dut_res()), 64'd0);
    chk("reset_ready_in", 64'(bus.o_ready_in), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready_in", 64'(bus.o_ready_in), 64'd1);
    @(posedge clk); #1;

    directed("rne_tie_odd", 0, 8'h7F, 28'hFFFFFF8, 3'd0, 0, {1'b0, 8'h80, 23'h0, 1'b0, 1'b0, 1'b1});
    directed("rne_tie_even", 0, 8'h40, 28'h8000008, 3'd0, 0, {1'b0, 8'h40, 23'h0, 1'b0, 1'b0, 1'b1});
    directed("rmm_tie", 0, 8'h40, 28'h8000008, 3'd4, 0, {1'b0, 8'h40, 23'h1, 1'b0, 1'b0, 1'b1});
    directed("ov_rne", 0, 8'hFE, 28'hFFFFFF8, 3'd0, 0, {1'b0, 8'hFF, 23'h0, 1'b1, 1'b0, 1'b1});
    directed("ov_rtz", 0, 8'hFE, 28'hFFFFFF8, 3'd1, 0, {1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b1});
    directed("ov_rdn_neg", 1, 8'hFE, 28'hFFFFFF8, 3'd2, 0, {1'b1, 8'hFF, 23'h0, 1'b1, 1'b0, 1'b1});
    directed("ov_rup_neg", 1, 8'hFE, 28'hFFFFFF8, 3'd3, 0, {1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b1});
    for (int r = 0; r < 4; r++)
      directed("exact_un", 0, 8'h10, 28'h8000000, 3'(r), 1, {1'b0, 8'h10, 23'h0, 1'b0, 1'b1, 1'b0});
    directed("special", 0, 8'hFF, 28'hC000007, 3'd0, 1, {1'b0, 8'hFF, 23'h400000, 1'b0, 1'b0, 1'b0});
    directed("rm7_as_rne", 0, 8'h7F, 28'hFFFFFF8, 3'd7, 0, {1'b0, 8'h80, 23'h0, 1'b0, 1'b0, 1'b1});
    drain();

    // Back-pressure: two beats fill the pipe, then two more wait for i_ready.
    bus.i_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    @(negedge clk);
    chk("bp_ready_drop", 64'(bus.o_ready_in), 64'd0);
    chk("bp_valid_held", 64'(bus.o_valid), 64'd1);
    @(posedge clk); #1;
    fork
      begin send(rand_beat()); send(rand_beat()); end
      begin repeat (3) @(posedge clk); #1; bus.i_ready = 1'b1; end
    join
    drain();

    // Reset with both stages occupied.
    bus.i_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_outputs", 64'(dut_res()), 64'd0);
    chk("midrst_ready_in", 64'(bus.o_ready_in), 64'd1);
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("after_rst_ready_in", 64'(bus.o_ready_in), 64'd1);
    chk("after_rst_valid", 64'(bus.o_valid), 64'd0);
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          b = rand_beat();
          send(b);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
